// File: rtl/div_arbiter.sv
// ---------------------------------------------------------------------------
// div_arbiter
//   Shares one sequential divider between two requesters. Round-robin grant,
//   operand latch, one-cycle divider start, then waits for the divider's
//   terminal pulse and returns quotient + status on a one-cycle done pulse.
//
// Parameters
//   DW         operand / quotient width
//   TO_CYCLES  watchdog limit in clocks (only with DIV_TIMEOUT_EN)
//
// Build option
//   DIV_TIMEOUT_EN  when defined, a watchdog aborts a hung divider with a
//                   one-cycle div_sclr and status 11. When undefined the
//                   arbiter waits indefinitely and div_sclr is tied 0.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req0/req1              level requests, held until their done edge
//   a0,b0 / a1,b1          per-port dividend / divisor
//   done[1:0]              one-cycle completion pulse, bit i = port i
//   q_out, st_out          quotient and status (00 ok,01 dvz,10 ovf,11 tmo)
//   arb_busy               high whenever the FSM is not in IDLE
//   div_start, div_sclr    one-cycle start / synchronous clear to divider
//   div_a, div_b           latched operands to divider
//   div_busy, div_valid,
//   div_dvz, div_ovf, div_q divider status and result
// ---------------------------------------------------------------------------
module div_arbiter #(
  parameter int DW        = 10,
  parameter int TO_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] b0,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] b1,
  output logic [1:0]    done,
  output logic [DW-1:0] q_out,
  output logic [1:0]    st_out,
  output logic          arb_busy,
  output logic          div_start,
  output logic          div_sclr,
  output logic [DW-1:0] div_a,
  output logic [DW-1:0] div_b,
  input  logic          div_busy,
  input  logic          div_valid,
  input  logic          div_dvz,
  input  logic          div_ovf,
  input  logic [DW-1:0] div_q
);

  localparam int NP = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    RUN       = 3'd3,
    RESP      = 3'd4
  } state_t;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_DVZ = 2'b01;
  localparam logic [1:0] ST_OVF = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  state_t                 r_state, w_next;
  logic                   r_last;   // port served most recently
  logic                   r_win;    // port owning the current transaction
  logic                   w_win;
  logic                   w_any;
  logic                   w_term;   // any divider terminal pulse
  logic                   w_tmo;    // watchdog expiry this cycle
  logic                   w_wait;   // waiting on the divider
  logic [NP-1:0]          w_req;
  logic [NP-1:0][DW-1:0]  w_a, w_b;

  assign w_req  = {req1, req0};
  assign w_a    = {a1, a0};
  assign w_b    = {b1, b0};
  assign w_any  = |w_req;
  assign w_term = div_valid | div_dvz | div_ovf;
  assign w_wait = (r_state == WAIT_BUSY) || (r_state == RUN);

  // Sole requester wins outright; on a tie the port not served last wins.
  assign w_win = (&w_req) ? ~r_last : w_req[1];

`ifdef DIV_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (r_state == ISSUE) r_cnt <= '0;
    else if (w_wait)           r_cnt <= r_cnt + CW'(1);
  end

  // The counter value seen here is the number of waiting cycles already
  // elapsed, so TO_CYCLES-1 marks the cycle the limit is reached. A real
  // terminal pulse in that same cycle takes priority.
  assign w_tmo = w_wait && (r_cnt == CW'(TO_CYCLES - 1)) && !w_term;
`else
  logic w_unused_to;
  assign w_unused_to = (TO_CYCLES > 0);
  assign w_tmo       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (w_any) w_next = ISSUE;
      ISSUE:     w_next = WAIT_BUSY;
      // A terminal pulse coincident with busy rising still completes.
      WAIT_BUSY: if (w_term || w_tmo) w_next = RESP;
                 else if (div_busy)   w_next = RUN;
      RUN:       if (w_term || w_tmo) w_next = RESP;
      RESP:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    arb_busy  = (r_state != IDLE);
    div_start = (r_state == ISSUE);
    div_sclr  = w_tmo;
  end

  for (genvar gi = 0; gi < NP; gi++) begin : g_done
    assign done[gi] = (r_state == RESP) && (r_win == 1'(gi));
  end

  // Grant, operand latch and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      r_win  <= 1'b0;
      div_a  <= '0;
      div_b  <= '0;
      q_out  <= '0;
      st_out <= ST_OK;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_win <= w_win;
            div_a <= w_a[w_win];
            div_b <= w_b[w_win];
          end
        end
        WAIT_BUSY, RUN: begin
          if (w_term) begin
            q_out  <= div_valid ? div_q : '0;
            st_out <= div_valid ? ST_OK : (div_dvz ? ST_DVZ : ST_OVF);
          end else if (w_tmo) begin
            q_out  <= '0;
            st_out <= ST_TMO;
          end
        end
        RESP: begin
          r_last <= r_win;
          q_out  <= '0;
          st_out <= ST_OK;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;

  localparam int DW = 10;

  logic          clk, rst_n;
  logic          req0, req1;
  logic [DW-1:0] a0, b0, a1, b1;
  logic [1:0]    done;
  logic [DW-1:0] q_out;
  logic [1:0]    st_out;
  logic          arb_busy, div_start, div_sclr;
  logic [DW-1:0] div_a, div_b;
  logic          div_busy, div_valid, div_dvz, div_ovf;
  logic [DW-1:0] div_q;

  div_arbiter #(.DW(DW), .TO_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .done(done), .q_out(q_out), .st_out(st_out),
    .arb_busy(arb_busy), .div_start(div_start), .div_sclr(div_sclr),
    .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_valid(div_valid), .div_dvz(div_dvz),
    .div_ovf(div_ovf), .div_q(div_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Snapshot of DUT outputs taken at each falling edge
  logic [1:0]    s_done, s_st;
  logic [DW-1:0] s_q, s_a, s_b;
  logic          s_start, s_sclr, s_busy;

  // Behavioural divider: mode 0 divides, 1 forces overflow, 2 hangs busy.
  int            dv_mode = 0;
  int            dv_lat  = 0;
  int            dv_cnt  = 0;
  logic [DW-1:0] dv_a, dv_b;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    s_done = done;  s_q = q_out;  s_st = st_out;
    s_start = div_start; s_sclr = div_sclr; s_busy = arb_busy;
    s_a = div_a; s_b = div_b;
    div_valid = 1'b0; div_dvz = 1'b0; div_ovf = 1'b0; div_q = '0;
    if (s_sclr) div_busy = 1'b0;
    else if (s_start) begin
      dv_a = s_a; dv_b = s_b; div_busy = 1'b1; dv_cnt = dv_lat;
    end else if (div_busy && dv_mode != 2) begin
      if (dv_cnt == 0) begin
        div_busy = 1'b0;
        if (dv_mode == 1)     div_ovf = 1'b1;
        else if (dv_b == '0)  div_dvz = 1'b1;
        else begin div_valid = 1'b1; div_q = dv_a / dv_b; end
      end else dv_cnt--;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    div_busy = 1'b0; div_valid = 1'b0; div_dvz = 1'b0; div_ovf = 1'b0; div_q = '0;
    dv_mode = 0;
    #1;
    chk("reset_outputs", 64'({done, q_out, st_out, arb_busy, div_start, div_sclr, div_a, div_b}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait for a done pulse; the requester drops its req on that cycle.
  task automatic wait_done(output logic [1:0] d, output logic [DW-1:0] q,
                           output logic [1:0] st, output int n);
    bit got;
    got = 0; n = 0; d = '0; q = '0; st = '0;
    while (!got && n < 100) begin
      cycle(); n++;
      if (s_done != 2'b00) begin
        got = 1; d = s_done; q = s_q; st = s_st;
        if (s_done[0]) req0 = 1'b0;
        if (s_done[1]) req1 = 1'b0;
      end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL wait_done: no done within 100 cycles, got 0 expected pulse");
    end
  endtask

  typedef struct {
    logic          rst;
    logic [1:0]    mask;
    logic [DW-1:0] a0, b0, a1, b1;
    logic          ovf;
    int            lat;
    logic [1:0]    d1;  logic [DW-1:0] q1;  logic [1:0] s1;
    logic [1:0]    d2;  logic [DW-1:0] q2;  logic [1:0] s2;
  } vec_t;

  vec_t tv[6];

  logic [1:0]    d, st;
  logic [DW-1:0] q;
  int            n;

  // random-phase model state
  logic          rq[2];
  logic [DW-1:0] ra[2], rb[2];
  logic          m_act, m_last, m_win, just;
  int            m_issue, m_done;
  logic [DW-1:0] e_q;
  logic [1:0]    e_st, e_done;
  logic          e_start;

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    div_busy = 1'b0; div_valid = 1'b0; div_dvz = 1'b0; div_ovf = 1'b0; div_q = '0;

    //        rst   mask   a0       b0      a1       b1      ovf  lat d1     q1       s1     d2     q2        s2
    tv[0] = '{1'b1, 2'b01, 10'd100, 10'd7,  10'd0,   10'd0,   1'b0, 3, 2'b01, 10'd14, 2'b00, 2'b00, 10'd0,    2'b00};
    tv[1] = '{1'b1, 2'b11, 10'd50,  10'd5,  10'd9,   10'd3,   1'b0, 2, 2'b01, 10'd10, 2'b00, 2'b10, 10'd3,    2'b00};
    tv[2] = '{1'b0, 2'b10, 10'd0,   10'd0,  10'd33,  10'd0,   1'b0, 1, 2'b10, 10'd0,  2'b01, 2'b00, 10'd0,    2'b00};
    tv[3] = '{1'b0, 2'b01, 10'd1000,10'd3,  10'd0,   10'd0,   1'b1, 0, 2'b01, 10'd0,  2'b10, 2'b00, 10'd0,    2'b00};
    tv[4] = '{1'b0, 2'b11, 10'd1023,10'd1,  10'd1000,10'd999, 1'b0, 0, 2'b10, 10'd1,  2'b00, 2'b01, 10'd1023, 2'b00};
    tv[5] = '{1'b0, 2'b01, 10'd0,   10'd5,  10'd0,   10'd0,   1'b0, 5, 2'b01, 10'd0,  2'b00, 2'b00, 10'd0,    2'b00};

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 6; i++) begin
      if (tv[i].rst) do_reset();
      cycle();
      a0 = tv[i].a0; b0 = tv[i].b0; a1 = tv[i].a1; b1 = tv[i].b1;
      dv_mode = tv[i].ovf ? 1 : 0; dv_lat = tv[i].lat;
      req0 = tv[i].mask[0]; req1 = tv[i].mask[1];
      wait_done(d, q, st, n);
      chk($sformatf("vec%0d_done1", i), 64'(d),  64'(tv[i].d1));
      chk($sformatf("vec%0d_q1", i),    64'(q),  64'(tv[i].q1));
      chk($sformatf("vec%0d_st1", i),   64'(st), 64'(tv[i].s1));
      chk($sformatf("vec%0d_lat1", i),  64'(n),  64'(3 + tv[i].lat));
      if (tv[i].d2 != 2'b00) begin
        wait_done(d, q, st, n);
        chk($sformatf("vec%0d_done2", i), 64'(d),  64'(tv[i].d2));
        chk($sformatf("vec%0d_q2", i),    64'(q),  64'(tv[i].q2));
        chk($sformatf("vec%0d_st2", i),   64'(st), 64'(tv[i].s2));
        chk($sformatf("vec%0d_lat2", i),  64'(n),  64'(4 + tv[i].lat));
      end
    end

    // ---------------- single start pulse, withdraw + operand change ----------------
    begin
      int starts;
      logic [DW-1:0] sa, sb;
      logic [1:0] dd;
      logic [DW-1:0] dq;
      starts = 0; sa = '0; sb = '0; dd = '0; dq = '0;
      do_reset(); cycle();
      dv_lat = 3; a0 = 10'd100; b0 = 10'd7; req0 = 1'b1;
      for (int i = 0; i < 40 && dd == 2'b00; i++) begin
        cycle();
        if (s_start) begin
          starts++; sa = s_a; sb = s_b;
          req0 = 1'b0; a0 = 10'd5; b0 = 10'd1;
        end
        if (s_done != 2'b00) begin dd = s_done; dq = s_q; end
      end
      chk("issue_start_count", 64'(starts), 64'(1));
      chk("issue_div_a", 64'(sa), 64'(100));
      chk("issue_div_b", 64'(sb), 64'(7));
      chk("withdraw_done", 64'(dd), 64'(2'b01));
      chk("withdraw_q", 64'(dq), 64'(14));
      cycle();
      chk("idle_after_resp", 64'(s_busy), 64'(0));
    end

    // ---------------- continuous contention ----------------
    do_reset(); cycle();
    dv_lat = 1; a0 = 10'd20; b0 = 10'd4; a1 = 10'd30; b1 = 10'd3;
    req0 = 1'b1; req1 = 1'b1;
    for (int t = 0; t < 6; t++) begin
      wait_done(d, q, st, n);
      chk($sformatf("alt%0d_port", t), 64'(d), 64'((t % 2) ? 2'b10 : 2'b01));
      chk($sformatf("alt%0d_q", t),    64'(q), 64'((t % 2) ? 10 : 5));
      if (t < 5) begin req0 = 1'b1; req1 = 1'b1; end
      else       begin req0 = 1'b0; req1 = 1'b0; end
    end

    // ---------------- reset mid-run ----------------
    begin
      logic [1:0] seen;
      seen = '0;
      do_reset(); cycle();
      dv_mode = 2; a0 = 10'd9; b0 = 10'd3; req0 = 1'b1;
      repeat (6) cycle();
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_outputs", 64'({done, q_out, st_out, arb_busy, div_start, div_sclr, div_a, div_b}), 64'(0));
      req0 = 1'b0; dv_mode = 0; div_busy = 1'b0;
      repeat (2) cycle();
      rst_n = 1'b1;
      repeat (10) begin cycle(); seen = seen | s_done; end
      chk("midrun_no_done", 64'(seen), 64'(0));
    end

`ifdef DIV_TIMEOUT_EN
    // ---------------- watchdog ----------------
    begin
      int issue_at, sclr_at;
      issue_at = -1; sclr_at = -1;
      do_reset(); cycle();
      dv_mode = 2; a0 = 10'd10; b0 = 10'd2; req0 = 1'b1;
      for (int i = 0; i < 40 && sclr_at < 0; i++) begin
        cycle();
        if (s_start) issue_at = i;
        if (s_sclr)  sclr_at  = i;
      end
      chk("tmo_sclr_delay", 64'(sclr_at - issue_at), 64'(8));
      cycle();
      chk("tmo_done", 64'(s_done), 64'(2'b01));
      chk("tmo_st",   64'(s_st),   64'(2'b11));
      chk("tmo_q",    64'(s_q),    64'(0));
      req0 = 1'b0; dv_mode = 0;
    end
`endif

    // ---------------- randomized traffic vs transaction model ----------------
    do_reset(); cycle();
    rq[0] = 1'b0; rq[1] = 1'b0; ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0;
    m_act = 1'b0; m_last = 1'b1; m_win = 1'b0; m_issue = -1; m_done = -1;
    e_q = '0; e_st = '0;
    for (int k = 0; k < 3000; k++) begin
      cycle();
      just    = 1'b0;
      e_start = m_act && (k == m_issue);
      e_done  = (m_act && k == m_done) ? (m_win ? 2'b10 : 2'b01) : 2'b00;
      chk("rnd_done",  64'(s_done),  64'(e_done));
      chk("rnd_start", 64'(s_start), 64'(e_start));
      chk("rnd_sclr",  64'(s_sclr),  64'(0));
      if (e_start) begin
        chk("rnd_div_a", 64'(s_a), 64'(ra[m_win]));
        chk("rnd_div_b", 64'(s_b), 64'(rb[m_win]));
      end
      if (e_done != 2'b00) begin
        chk("rnd_q",  64'(s_q),  64'(e_q));
        chk("rnd_st", 64'(s_st), 64'(e_st));
        rq[m_win] = 1'b0; m_last = m_win; m_act = 1'b0; just = 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
        if (!rq[p] && !(just && m_win == 1'(p)) && $urandom_range(3) == 0) begin
          rq[p] = 1'b1;
          ra[p] = DW'($urandom_range(1023));
          rb[p] = ($urandom_range(7) == 0) ? '0 : DW'($urandom_range(40, 1));
        end
      end
      req0 = rq[0]; a0 = ra[0]; b0 = rb[0];
      req1 = rq[1]; a1 = ra[1]; b1 = rb[1];
      if (!m_act && !just && (rq[0] || rq[1])) begin
        m_win   = (rq[0] && rq[1]) ? ~m_last : rq[1];
        dv_lat  = int'($urandom_range(6));
        dv_mode = ($urandom_range(9) == 0) ? 1 : 0;
        m_issue = k + 1;
        m_done  = k + 3 + dv_lat;
        if (dv_mode == 1)           begin e_q = '0; e_st = 2'b10; end
        else if (rb[m_win] == '0)   begin e_q = '0; e_st = 2'b01; end
        else begin e_q = ra[m_win] / rb[m_win]; e_st = 2'b00; end
        m_act = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
